// File: rtl/mult_unit_ss.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU.
// Operates on magnitudes; the sign is applied once in DONE.
module mult_unit_ss #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start_mult,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             MultFlush,
  output logic             mult_ready,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] res;

  always_comb begin
    abs_a = SrcA;
    abs_b = SrcB;
    if (is_signed && SrcA[WIDTH-1])
      abs_a = (~SrcA) + WIDTH'(1);
    if (is_signed && SrcB[WIDTH-1])
      abs_b = (~SrcB) + WIDTH'(1);
  end

  // carry bit rides above the upper half so the shift keeps it
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (mplier[0])
      sum = sum + {1'b0, mcand};
  end

  always_comb begin
    res = acc;
    if (neg)
      res = (~acc) + (2*WIDTH)'(1);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      neg        <= 1'b0;
      cnt        <= '0;
      mult_ready <= 1'b0;
      HI         <= '0;
      LO         <= '0;
    end else begin
      mult_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start_mult) begin
            mcand  <= abs_a;
            mplier <= abs_b;
            neg    <= is_signed
                    & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (MultFlush) begin
            state <= IDLE;
          end else begin
            acc    <= {sum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1))
              state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (!MultFlush) begin
            HI         <= res[2*WIDTH-1:WIDTH];
            LO         <= res[WIDTH-1:0];
            mult_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit_ss.sv
// Scoreboard bench for mult_unit_ss.
// Driver queues expected products; a monitor checks each mult_ready.
module tb_mult_unit_ss;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start_mult;
  logic         is_signed;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         MultFlush;
  logic         mult_ready;
  logic         busy;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];

  mult_unit_ss #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start_mult(Start_mult),
    .is_signed (is_signed),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .MultFlush (MultFlush),
    .mult_ready(mult_ready),
    .busy      (busy),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] model(
    input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint unsigned ua;
    longint unsigned ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic issue(input bit s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit expect_res);
    is_signed  = s;
    SrcA       = a;
    SrcB       = b;
    Start_mult = 1'b1;
    if (expect_res) begin
      exp_q.push_back(model(s, a, b));
      exp_cyc_q.push_back(cyc + W + 2);
    end
    tick(1);
    Start_mult = 1'b0;
  endtask

  // leaves the driver inside the mult_ready cycle
  task automatic run_op(input bit s, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    issue(s, a, b, 1'b1);
    tick(W + 1);
  endtask

  always @(negedge clk) begin
    if (reset && mult_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: cyc %0d HI %h LO %h",
                 cyc, HI, LO);
      end else begin
        logic [2*W-1:0] e;
        int             ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        total++;
        if ({HI, LO} !== e) begin
          bad++;
          $display("FAIL product: got %h want %h", {HI, LO}, e);
        end
        total++;
        if (cyc != ec) begin
          bad++;
          $display("FAIL latency: got cyc %0d want %0d", cyc, ec);
        end
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_at_ready: got %b want 0", busy);
        end
      end
    end
  end

  initial begin
    reset      = 1'b0;
    Start_mult = 1'b0;
    is_signed  = 1'b0;
    SrcA       = '0;
    SrcB       = '0;
    MultFlush  = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(mult_ready), 64'd0);

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    tick(1);
    chk("ready_width", 64'(mult_ready), 64'd0);

    run_op(1'b1, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000);
    chk("mult_min", {HI, LO}, 64'h4000_0000_0000_0000);

    // back-to-back: each run_op starts inside the ready cycle
    run_op(1'b0, 32'd2, 32'd3);
    chk("b2b_first", 64'(LO), 64'd6);
    run_op(1'b0, 32'd4, 32'd5);
    chk("b2b_second", 64'(LO), 64'd20);
    tick(1);

    // start while busy is ignored
    issue(1'b1, 32'd5, 32'd6, 1'b1);
    tick(8);
    chk("busy_mid", 64'(busy), 64'd1);
    SrcA       = 32'd9;
    SrcB       = 32'd9;
    Start_mult = 1'b1;
    tick(1);
    Start_mult = 1'b0;
    tick(W - 8);
    chk("ignore_start", {HI, LO}, 64'd30);
    tick(3);

    // flush together with start in IDLE still starts
    MultFlush = 1'b1;
    issue(1'b0, 32'd123, 32'd456, 1'b0);
    MultFlush = 1'b0;
    chk("flush_start_busy", 64'(busy), 64'd1);
    tick(13);
    MultFlush = 1'b1;
    tick(1);
    MultFlush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hilo", {HI, LO}, 64'd30);
    tick(40);
    chk("flush_hold", {HI, LO}, 64'd30);

    issue(1'b0, 32'd777, 32'd999, 1'b0);
    tick(18);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("mrst_hilo", {HI, LO}, 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ready", 64'(mult_ready), 64'd0);
    tick(40);
    chk("mrst_hold", {HI, LO}, 64'd0);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      b = $urandom;
      if (i % 6 == 1) a = 32'h8000_0000;
      if (i % 6 == 3) b = 32'hFFFF_FFFF;
      if (i % 6 == 5) b = 32'd0;
      run_op(1'($urandom_range(0, 1)), a, b);
      tick($urandom_range(0, 2));
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++)
      tick(1);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL missing_ready: got %0d pending want 0",
               exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
